// File: rtl/div_arb_pkg.sv
// Shared definitions for the divider arbiter: FSM state encoding and the
// quotient returned for a zero divisor when the bypass path is built in.
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int                    MAX_XLEN     = 64;
  localparam logic [MAX_XLEN-1:0]   DIV_ZERO_QUO = '1;

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after 'last', with wrap.
// The pointer register is owned by the instantiating block.
module rr_arbiter
  import div_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  last_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  gnt_idx_o,
  output logic            gnt_any_o
);

  logic [IDW-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_i) + k) % NREQ);
      if (!gnt_any_o && req_i[idx]) begin
        gnt_any_o  = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sharing of one iterative divider between NREQ requesters.
// Optional DIV_ARB_ZERO_BYPASS_EN answers b==0 locally without the divider.
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_vld,
  output logic [NREQ-1:0]      req_rdy,
  input  logic [NREQ*XLEN-1:0] req_a,
  input  logic [NREQ*XLEN-1:0] req_b,
  output logic [NREQ-1:0]      rsp_vld,
  input  logic [NREQ-1:0]      rsp_rdy,
  output logic [XLEN-1:0]      rsp_quo,
  output logic [XLEN-1:0]      rsp_rem,
  output logic [IDW-1:0]       rsp_id,
  output logic                 div_vld,
  output logic [XLEN-1:0]      div_a,
  output logic [XLEN-1:0]      div_b,
  input  logic                 div_ack,
  input  logic [XLEN-1:0]      div_quo,
  input  logic [XLEN-1:0]      div_rem
);

  // state | meaning
  // IDLE  | arbitrate, accept one request
  // ISSUE | div_vld pulse; an immediate div_ack is taken here
  // WAIT  | waiting for div_ack
  // RESP  | result held for the owner until its rsp_rdy
  state_e          state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  last_q,  last_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d;

  logic [NREQ-1:0] gnt_oh;
  logic [IDW-1:0]  gnt_idx;
  logic            gnt_any;
  logic [XLEN-1:0] sel_a, sel_b;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req_i     (req_vld),
    .last_i    (last_q),
    .gnt_o     (gnt_oh),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign sel_a = req_a[int'(gnt_idx)*XLEN +: XLEN];
  assign sel_b = req_b[int'(gnt_idx)*XLEN +: XLEN];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    req_rdy = '0;
    div_vld = 1'b0;
    rsp_vld = '0;
    case (state_q)
      IDLE: begin
        req_rdy = gnt_oh;
        if (gnt_any) begin
          owner_d = gnt_idx;
          last_d  = gnt_idx;
`ifdef DIV_ARB_ZERO_BYPASS_EN
          if (sel_b == '0) begin
            quo_d   = DIV_ZERO_QUO[XLEN-1:0];
            rem_d   = sel_a;
            state_d = RESP;
          end else begin
            a_d     = sel_a;
            b_d     = sel_b;
            state_d = ISSUE;
          end
`else
          a_d     = sel_a;
          b_d     = sel_b;
          state_d = ISSUE;
`endif
        end
      end
      ISSUE: begin
        div_vld = 1'b1;
        if (div_ack) begin
          quo_d   = div_quo;
          rem_d   = div_rem;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (div_ack) begin
          quo_d   = div_quo;
          rem_d   = div_rem;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_vld = NREQ'(1) << owner_q;
        if (rsp_rdy[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDW'(NREQ-1);
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign div_a   = a_q;
  assign div_b   = b_q;
  assign rsp_quo = quo_q;
  assign rsp_rem = rem_q;
  assign rsp_id  = owner_q;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed scenarios plus random traffic against a
// timestamp-based reference model and a behavioural divider stand-in.
module tb_div_arbiter;

  localparam int XLEN = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_vld, req_rdy, rsp_vld, rsp_rdy;
  logic [NREQ*XLEN-1:0] req_a, req_b;
  logic [XLEN-1:0]      rsp_quo, rsp_rem, div_a, div_b, div_quo, div_rem;
  logic [IDW-1:0]       rsp_id;
  logic                 div_vld, div_ack;

  always #5 clk = ~clk;

  div_arbiter #(.XLEN(XLEN), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_a(req_a), .req_b(req_b),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_quo(rsp_quo), .rsp_rem(rsp_rem),
    .rsp_id(rsp_id),
    .div_vld(div_vld), .div_a(div_a), .div_b(div_b),
    .div_ack(div_ack), .div_quo(div_quo), .div_rem(div_rem)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // stimulus state
  logic [NREQ-1:0] pend;
  logic [XLEN-1:0] op_a [NREQ];
  logic [XLEN-1:0] op_b [NREQ];
  logic [NREQ-1:0] rsp_rdy_v;
  logic            rst_v, stray_ack;
  bit              rearm;
  int              dv_lat;

  // reference model
  int              cyc;
  bit              m_busy, m_acked;
  int              m_owner, m_last, m_issue_at, m_rsp_from;
  logic [XLEN-1:0] m_a, m_b, m_quo, m_rem;
  int              grant_log[$];
  int              served_log[$];
  logic [XLEN-1:0] q_log[$];
  logic [XLEN-1:0] r_log[$];
  int              n_div;

  // divider stand-in
  bit              dv_pend;
  int              dv_cnt;
  logic [XLEN-1:0] dv_a, dv_b;

  function automatic logic [XLEN-1:0] ref_quo(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return (b == '0) ? '1 : a / b;
  endfunction

  function automatic logic [XLEN-1:0] ref_rem(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return (b == '0) ? a : a % b;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++)
      if (v[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_busy     = 0;
    m_acked    = 0;
    m_owner    = 0;
    m_last     = NREQ - 1;
    m_issue_at = -1;
    m_rsp_from = 0;
    dv_pend    = 0;
  endtask

  // One clock cycle, entered and left at a negative edge.
  task automatic step();
    logic [NREQ-1:0] exp_rsp, exp_rdy;
    bit              exp_div;
    int              g;
    exp_div = m_busy && (cyc == m_issue_at);
    exp_rsp = (m_busy && m_acked && cyc >= m_rsp_from) ? onehot(m_owner) : '0;
    check_eq("div_vld", 64'(div_vld), 64'(exp_div));
    if (div_vld) n_div++;
    if (exp_div) begin
      check_eq("div_a", 64'(div_a), 64'(m_a));
      check_eq("div_b", 64'(div_b), 64'(m_b));
    end
    check_eq("rsp_vld", 64'(rsp_vld), 64'(exp_rsp));
    if (exp_rsp != '0) begin
      check_eq("rsp_id",  64'(rsp_id),  64'(m_owner));
      check_eq("rsp_quo", 64'(rsp_quo), 64'(m_quo));
      check_eq("rsp_rem", 64'(rsp_rem), 64'(m_rem));
    end

    div_ack = 1'b0;
    div_quo = '0;
    div_rem = '0;
    if (div_vld && !dv_pend) begin
      dv_pend = 1;
      dv_a    = div_a;
      dv_b    = div_b;
      dv_cnt  = (dv_lat < 0) ? int'($urandom_range(0, 4)) : dv_lat;
    end
    if (dv_pend) begin
      if (dv_cnt == 0) begin
        div_ack = 1'b1;
        div_quo = ref_quo(dv_a, dv_b);
        div_rem = ref_rem(dv_a, dv_b);
        dv_pend = 0;
      end else begin
        dv_cnt--;
      end
    end
    if (stray_ack) begin
      div_ack = 1'b1;
      div_quo = $urandom;
      div_rem = $urandom;
    end
    if (div_ack && m_busy && !m_acked && m_issue_at >= 0 && cyc >= m_issue_at) begin
      m_acked    = 1;
      m_rsp_from = cyc + 1;
    end

    rst     = rst_v;
    req_vld = pend;
    rsp_rdy = rsp_rdy_v;
    for (int i = 0; i < NREQ; i++) begin
      req_a[i*XLEN +: XLEN] = op_a[i];
      req_b[i*XLEN +: XLEN] = op_b[i];
    end
    #1;
    g       = m_busy ? -1 : rr_pick(m_last, pend);
    exp_rdy = (g < 0) ? '0 : onehot(g);
    check_eq("req_rdy", 64'(req_rdy), 64'(exp_rdy));

    if (exp_rsp != '0 && rsp_rdy_v[m_owner]) begin
      served_log.push_back(m_owner);
      q_log.push_back(rsp_quo);
      r_log.push_back(rsp_rem);
      m_busy = 0;
    end
    if (g >= 0) begin
      grant_log.push_back(g);
      m_busy     = 1;
      m_owner    = g;
      m_last     = g;
      m_a        = op_a[g];
      m_b        = op_b[g];
      m_quo      = ref_quo(m_a, m_b);
      m_rem      = ref_rem(m_a, m_b);
      m_acked    = 0;
      m_issue_at = cyc + 1;
`ifdef DIV_ARB_ZERO_BYPASS_EN
      if (m_b == '0) begin
        m_issue_at = -1;
        m_acked    = 1;
        m_rsp_from = cyc + 1;
      end
`endif
      if (!rearm) pend[g] = 1'b0;
    end
    if (rst_v) model_reset();

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_zero"}, {div_vld, rsp_vld, req_rdy, rsp_id, 1'b0},
             '0);
    check_eq({tag, "_zero_data"}, 64'(div_a | div_b | rsp_quo | rsp_rem), 64'd0);
  endtask

  task automatic do_reset();
    pend  = '0;
    rst_v = 1'b1;
    step();
    rst_v = 1'b0;
    check_zero_outputs("reset");
  endtask

  task automatic wait_served(input int target, input int budget);
    int n;
    n = 0;
    while (served_log.size() < target && n < budget) begin
      step();
      n++;
    end
    check_eq("served_count", 64'(served_log.size()), 64'(target));
  endtask

  task automatic set_req(input int i, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    op_a[i] = a;
    op_b[i] = b;
    pend[i] = 1'b1;
  endtask

  int base, nd0, n;

  initial begin
    pend = '0; rsp_rdy_v = '1; rst_v = 1'b0; stray_ack = 1'b0; rearm = 0; dv_lat = 2;
    for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
    req_vld = '0; req_a = '0; req_b = '0; rsp_rdy = '1;
    div_ack = 1'b0; div_quo = '0; div_rem = '0;
    rst = 1'b1;
    cyc = 0; n_div = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("por");

    // single request
    set_req(0, 32'd10, 32'd7);
    wait_served(1, 40);
    check_eq("t1_id",   64'(served_log[0]), 64'd0);
    check_eq("t1_quo",  64'(q_log[0]), 64'd1);
    check_eq("t1_rem",  64'(r_log[0]), 64'd3);
    check_eq("t1_ndiv", 64'(n_div), 64'd1);

    // contention from reset, then pointer wrap
    do_reset();
    set_req(0, 32'd100, 32'd7);
    set_req(1, 32'd100, 32'd100);
    wait_served(3, 60);
    check_eq("t2_first",  64'(served_log[1]), 64'd0);
    check_eq("t2_quo0",   64'(q_log[1]), 64'd14);
    check_eq("t2_rem0",   64'(r_log[1]), 64'd2);
    check_eq("t2_second", 64'(served_log[2]), 64'd1);
    check_eq("t2_quo1",   64'(q_log[2]), 64'd1);
    check_eq("t2_rem1",   64'(r_log[2]), 64'd0);
    set_req(0, 32'd55, 32'd5);
    set_req(1, 32'd56, 32'd5);
    wait_served(5, 60);
    check_eq("t2_wrap", 64'(served_log[3]), 64'd0);

    // fairness with all requesters held
    do_reset();
    dv_lat = -1;
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, 32'($urandom_range(1, 1000)));
    rearm = 1;
    base  = grant_log.size();
    n = 0;
    while (grant_log.size() < base + 5 && n < 200) begin step(); n++; end
    rearm = 0;
    pend  = '0;
    wait_served(served_log.size() + (m_busy ? 1 : 0), 40);
    for (int k = 0; k < 5; k++)
      check_eq($sformatf("t3_grant%0d", k), 64'(grant_log[base + k]), 64'(k % NREQ));

    // backpressure on owner, stray ready from a non-owner
    dv_lat = 3;
    base = served_log.size();
    set_req(2, 32'd70, 32'd150);
    rsp_rdy_v = 4'b1011;
    n = 0;
    while (!(m_busy && m_acked && cyc >= m_rsp_from) && n < 40) begin step(); n++; end
    set_req(1, 32'd9, 32'd2);
    rsp_rdy_v = 4'b0001;
    repeat (5) step();
    check_eq("t4_held", 64'(served_log.size()), 64'(base));
    rsp_rdy_v = '1;
    wait_served(base + 2, 60);
    check_eq("t4_id",  64'(served_log[base]), 64'd2);
    check_eq("t4_quo", 64'(q_log[base]), 64'd0);
    check_eq("t4_rem", 64'(r_log[base]), 64'd70);

    // reset while waiting on the divider
    dv_lat = 4;
    base = served_log.size();
    set_req(3, 32'd50, 32'd3);
    n = 0;
    while (!(m_busy && !m_acked && m_issue_at >= 0 && cyc > m_issue_at) && n < 40) begin step(); n++; end
    do_reset();
    stray_ack = 1'b1;
    step();
    stray_ack = 1'b0;
    repeat (3) step();
    check_eq("t5_no_rsp",  64'(rsp_vld), 64'd0);
    check_eq("t5_dropped", 64'(served_log.size()), 64'(base));
    set_req(1, 32'd9, 32'd4);
    wait_served(base + 1, 40);
    check_eq("t5_quo", 64'(q_log[base]), 64'd2);
    check_eq("t5_rem", 64'(r_log[base]), 64'd1);

    // divide by zero
    dv_lat = 1;
    base = served_log.size();
    nd0  = n_div;
    set_req(0, 32'd100, 32'd0);
    wait_served(base + 1, 40);
    check_eq("t6_quo", 64'(q_log[base]), 64'hFFFF_FFFF);
    check_eq("t6_rem", 64'(r_log[base]), 64'd100);
`ifdef DIV_ARB_ZERO_BYPASS_EN
    check_eq("t6_ndiv", 64'(n_div - nd0), 64'd0);
`else
    check_eq("t6_ndiv", 64'(n_div - nd0), 64'd1);
`endif

    // random traffic
    dv_lat = -1;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          op_a[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 500));
          case ($urandom_range(0, 7))
            0:       op_b[i] = '0;
            1, 2, 3: op_b[i] = 32'($urandom_range(1, 20));
            default: op_b[i] = $urandom;
          endcase
          pend[i] = 1'b1;
        end else if (pend[i] && $urandom_range(0, 15) == 0) begin
          pend[i] = 1'b0;
        end
      end
      rsp_rdy_v = NREQ'($urandom);
      step();
    end
    pend = '0;
    rsp_rdy_v = '1;
    n = 0;
    while (m_busy && n < 40) begin step(); n++; end
    check_eq("drain_idle", 64'(m_busy), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
